// File: rtl/usb3_ep_in_sched.sv
// Round-robin IN scheduler: grants the shared protocol-layer transmit path to one endpoint buffer, then re-arms it.
// Latency: one cycle from eligibility to grant; read mux adds zero latency. Optional macro USB3_EP_IN_SCHED_RETRY_LIMIT_EN.
// Backpressure: holds a grant until prot_done; arm/release handshakes are bounded by ACK_TIMEOUT.
module usb3_ep_in_sched #(
  parameter int NUM_EP      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 local_clk,
  input  logic                 reset_n,
  input  logic [NUM_EP-1:0]    ep_hasdata,
  input  logic [NUM_EP-1:0]    ep_enable,
  input  logic [NUM_EP*11-1:0] ep_len,
  input  logic [NUM_EP*32-1:0] ep_q,
  output logic [8:0]           ep_addr,
  output logic [NUM_EP-1:0]    ep_arm,
  input  logic [NUM_EP-1:0]    ep_arm_ack,
  output logic                 prot_start,
  output logic [1:0]           prot_ep,
  output logic [10:0]          prot_len,
  input  logic [8:0]           prot_addr,
  output logic [31:0]          prot_q,
  input  logic                 prot_done,
  input  logic                 prot_retry,
  output logic                 prot_busy,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_ARM,
    S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  timer_q;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  prot_ep_d;
  logic [10:0] prot_len_d;
  logic        timer_hit;

  // Per-endpoint views padded to four entries so 2-bit indices are always in range.
  logic [3:0]  elig4, has4, ack4, arm4;
  logic [10:0] len_arr [4];
  logic [31:0] q_arr   [4];
  logic [1:0]  grant_next;
  logic        grant_found;

`ifdef USB3_EP_IN_SCHED_RETRY_LIMIT_EN
  logic [1:0]  retry_cnt_q;
  logic        retry_inc;
`endif

  always_comb begin
    elig4 = '0;
    has4  = '0;
    ack4  = '0;
    elig4[NUM_EP-1:0] = ep_hasdata & ep_enable;
    has4[NUM_EP-1:0]  = ep_hasdata;
    ack4[NUM_EP-1:0]  = ep_arm_ack;
    for (int i = 0; i < 4; i++) begin
      len_arr[i] = '0;
      q_arr[i]   = '0;
    end
    for (int i = 0; i < NUM_EP; i++) begin
      len_arr[i] = ep_len[i*11 +: 11];
      q_arr[i]   = ep_q[i*32 +: 32];
    end
  end

  // Walk downward so the nearest endpoint after last_grant is the last one written.
  always_comb begin
    logic [1:0] idx;
    grant_next  = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = NUM_EP; k >= 1; k--) begin
      idx = 2'((int'(last_grant_q) + k) % NUM_EP);
      if (elig4[idx]) begin
        grant_next  = idx;
        grant_found = 1'b1;
      end
    end
  end

  assign ep_addr    = prot_addr;
  assign prot_q     = q_arr[prot_ep];
  assign prot_start = (state_q == S_START);
  assign prot_busy  = (state_q != S_IDLE);
  assign ep_arm     = arm4[NUM_EP-1:0];
  assign timer_hit  = (timer_q == 8'(ACK_TIMEOUT));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    prot_ep_d    = prot_ep;
    prot_len_d   = prot_len;
    arm4         = '0;
    err_timeout  = 1'b0;
`ifdef USB3_EP_IN_SCHED_RETRY_LIMIT_EN
    retry_inc    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          prot_ep_d  = grant_next;
          prot_len_d = len_arr[grant_next];
          state_d    = S_START;
        end
      end
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (prot_done) begin
          state_d = S_ARM;
        end else if (prot_retry) begin
`ifdef USB3_EP_IN_SCHED_RETRY_LIMIT_EN
          if (retry_cnt_q == 2'd3) begin
            // Give up on this endpoint for now; it stays eligible for a later turn.
            err_timeout  = 1'b1;
            last_grant_d = prot_ep;
            state_d      = S_IDLE;
          end else begin
            retry_inc  = 1'b1;
            prot_len_d = len_arr[prot_ep];
            state_d    = S_START;
          end
`else
          prot_len_d = len_arr[prot_ep];
          state_d    = S_START;
`endif
        end
      end
      S_ARM: begin
        if (ack4[prot_ep]) begin
          state_d = S_RELEASE;
        end else if (timer_hit) begin
          err_timeout = 1'b1;
          state_d     = S_RELEASE;
        end else begin
          arm4[prot_ep] = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!has4[prot_ep] && !ack4[prot_ep]) begin
          last_grant_d = prot_ep;
          state_d      = S_IDLE;
        end else if (timer_hit) begin
          err_timeout  = 1'b1;
          last_grant_d = prot_ep;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'(NUM_EP - 1);
      prot_ep      <= '0;
      prot_len     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      prot_ep      <= prot_ep_d;
      prot_len     <= prot_len_d;
    end
  end

  // Timer restarts on every state change and saturates rather than wrapping.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if (timer_q != 8'hFF) begin
      timer_q <= timer_q + 8'd1;
    end
  end

`ifdef USB3_EP_IN_SCHED_RETRY_LIMIT_EN
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      retry_cnt_q <= '0;
    end else if (retry_inc) begin
      retry_cnt_q <= retry_cnt_q + 2'd1;
    end
  end
`endif

endmodule
